// File: rtl/apb_master_bridge_if.sv
// Command/response port and APB requester bus of the APB master bridge.
// The master modport is the bridge's view; the slave modport is the view of the environment it connects to.
interface apb_master_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_write_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic                  rsp_valid_o;
   logic [DATA_WIDTH-1:0] rsp_rdata_o;
   logic                  rsp_err_o;
   logic                  rsp_timeout_o;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLAVEERR;

   modport master (
      input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLAVEERR
   );

   modport slave (
      output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLAVEERR
   );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: turns valid/ready commands into SETUP/ACCESS transfers and
// returns one registered response pulse per command, with a wait-state watchdog.
module apb_master_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16,
   parameter int CNT_WIDTH  = 16
) (
   input logic PCLK,
   input logic PRESET,
   apb_master_bridge_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam bit                   WD_EN_S    = (TIMEOUT != 0);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST_S = WD_EN_S ? CNT_WIDTH'(TIMEOUT - 1) : '0;

   state_t                  state_r;
   logic [CNT_WIDTH-1:0]    cnt_r;
   logic [ADDR_WIDTH-1:0]   paddr_r;
   logic [DATA_WIDTH-1:0]   pwdata_r;
   logic                    pwrite_r;
   logic                    psel_r;
   logic                    penable_r;
   logic                    rsp_valid_r;
   logic [DATA_WIDTH-1:0]   rsp_rdata_r;
   logic                    rsp_err_r;
   logic                    rsp_timeout_r;

   // Transfer sequencer: IDLE -> SETUP -> ACCESS (waits/abort) -> IDLE with a registered response.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_r       <= IDLE;
         cnt_r         <= '0;
         paddr_r       <= '0;
         pwdata_r      <= '0;
         pwrite_r      <= 1'b0;
         psel_r        <= 1'b0;
         penable_r     <= 1'b0;
         rsp_valid_r   <= 1'b0;
         rsp_rdata_r   <= '0;
         rsp_err_r     <= 1'b0;
         rsp_timeout_r <= 1'b0;
      end else begin
         rsp_valid_r   <= 1'b0;
         rsp_rdata_r   <= '0;
         rsp_err_r     <= 1'b0;
         rsp_timeout_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.req_valid_i) begin
                  paddr_r  <= bus.req_addr_i;
                  pwdata_r <= bus.req_wdata_i;
                  pwrite_r <= bus.req_write_i;
                  psel_r   <= 1'b1;
                  cnt_r    <= '0;
                  state_r  <= SETUP;
               end else begin
                  state_r  <= IDLE;
               end
            end
            SETUP: begin
               penable_r <= 1'b1;
               state_r   <= ACCESS;
            end
            ACCESS: begin
               // PREADY takes priority over a watchdog expiry on the same edge.
               if (bus.PREADY) begin
                  psel_r      <= 1'b0;
                  penable_r   <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= bus.PSLAVEERR;
                  rsp_rdata_r <= pwrite_r ? '0 : bus.PRDATA;
                  state_r     <= IDLE;
               end else if (WD_EN_S && (cnt_r == CNT_LAST_S)) begin
                  psel_r        <= 1'b0;
                  penable_r     <= 1'b0;
                  rsp_valid_r   <= 1'b1;
                  rsp_err_r     <= 1'b1;
                  rsp_timeout_r <= 1'b1;
                  state_r       <= IDLE;
               end else begin
                  cnt_r   <= cnt_r + CNT_WIDTH'(1);
                  state_r <= ACCESS;
               end
            end
            default: begin
               psel_r    <= 1'b0;
               penable_r <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready_o   = (state_r == IDLE);
   assign bus.PADDR         = paddr_r;
   assign bus.PWDATA        = pwdata_r;
   assign bus.PWRITE        = pwrite_r;
   assign bus.PSEL          = psel_r;
   assign bus.PENABLE       = penable_r;
   assign bus.rsp_valid_o   = rsp_valid_r;
   assign bus.rsp_rdata_o   = rsp_rdata_r;
   assign bus.rsp_err_o     = rsp_err_r;
   assign bus.rsp_timeout_o = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a transaction-level model predicts every
// output each cycle, and per-command literal expectations pin that model.
module tb_apb_master_bridge;
   localparam int TO = 4;
   localparam int N  = 8;

   logic PCLK = 1'b0;
   logic PRESET;
   int   checks = 0;
   int   errors = 0;

   always #5 PCLK = ~PCLK;

   apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   apb_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO), .CNT_WIDTH(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;   // PREADY-low ACCESS cycles before the slave answers
      bit          err;
      int          gap;     // cycles after previous accept before req_valid rises
      int          exp_acc;
      logic [31:0] exp_rd;
      bit          exp_err;
      bit          exp_to;
   } cmd_t;

   cmd_t tbl [N];

   bit          busy = 1'b0;
   int          t = 0, n = 0, nxt = 0, gap_cnt = 0, rsp_idx = 0, acc_seen = 0;
   bit          cur_to = 1'b0;
   cmd_t        cur;
   logic [31:0] e_paddr = '0, e_pwdata = '0, e_rd = '0;
   bit          e_pwrite = 1'b0, e_rsp = 1'b0, e_err = 1'b0, e_to = 1'b0;
   bit          done = 1'b0;
   bit          seen = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   function automatic cmd_t mk(bit wr, logic [31:0] a, logic [31:0] wd, logic [31:0] rd, int w,
                               bit e, int g, int ea, logic [31:0] erd, bit ee, bit et);
      cmd_t c;
      c.wr = wr; c.addr = a; c.wdata = wd; c.rdata = rd; c.waits = w; c.err = e; c.gap = g;
      c.exp_acc = ea; c.exp_rd = erd; c.exp_err = ee; c.exp_to = et;
      return c;
   endfunction

   // One cycle: compare, drive inputs for this cycle, then advance the model to the next cycle.
   task automatic step();
      chk("psel",      bus.PSEL,          busy);
      chk("penable",   bus.PENABLE,       busy && (t >= 2));
      chk("req_ready", bus.req_ready_o,   !busy);
      chk("paddr",     bus.PADDR,         e_paddr);
      chk("pwdata",    bus.PWDATA,        e_pwdata);
      chk("pwrite",    bus.PWRITE,        e_pwrite);
      chk("rsp_valid", bus.rsp_valid_o,   e_rsp);
      chk("rsp_rdata", bus.rsp_rdata_o,   e_rd);
      chk("rsp_err",   bus.rsp_err_o,     e_err);
      chk("rsp_to",    bus.rsp_timeout_o, e_to);

      if (bus.PENABLE === 1'b1) acc_seen++;
      if (bus.rsp_valid_o === 1'b1) begin
         if (rsp_idx < N) begin
            chk("lit_acc_cycles", acc_seen,          tbl[rsp_idx].exp_acc);
            chk("lit_rdata",      bus.rsp_rdata_o,   tbl[rsp_idx].exp_rd);
            chk("lit_err",        bus.rsp_err_o,     tbl[rsp_idx].exp_err);
            chk("lit_timeout",    bus.rsp_timeout_o, tbl[rsp_idx].exp_to);
         end else begin
            chk("extra_rsp", rsp_idx, N - 1);
         end
         rsp_idx++;
         acc_seen = 0;
      end

      if (nxt < N && gap_cnt >= tbl[nxt].gap) begin
         bus.req_valid_i = 1'b1;
         bus.req_write_i = tbl[nxt].wr;
         bus.req_addr_i  = tbl[nxt].addr;
         bus.req_wdata_i = tbl[nxt].wdata;
      end else begin
         bus.req_valid_i = 1'b0;
         bus.req_write_i = 1'($urandom_range(1, 0));
         bus.req_addr_i  = $urandom;
         bus.req_wdata_i = $urandom;
      end
      if (busy && t >= 2) begin
         bus.PREADY    = ((t - 2) == cur.waits);
         bus.PSLAVEERR = bus.PREADY ? cur.err : 1'b1;
         bus.PRDATA    = bus.PREADY ? cur.rdata : $urandom;
      end else begin
         bus.PREADY    = 1'b1;
         bus.PSLAVEERR = 1'b1;
         bus.PRDATA    = $urandom;
      end

      e_rsp = 1'b0; e_rd = '0; e_err = 1'b0; e_to = 1'b0;
      gap_cnt++;
      if (busy) begin
         if (t == n + 1) begin
            busy  = 1'b0;
            e_rsp = 1'b1;
            e_to  = cur_to;
            e_err = cur_to ? 1'b1 : cur.err;
            e_rd  = (cur_to || cur.wr) ? 32'h0 : cur.rdata;
         end else begin
            t++;
         end
      end else if (bus.req_valid_i) begin
         cur      = tbl[nxt];
         busy     = 1'b1;
         t        = 1;
         cur_to   = (cur.waits >= TO);
         n        = cur_to ? TO : cur.waits + 1;
         e_paddr  = cur.addr;
         e_pwdata = cur.wdata;
         e_pwrite = cur.wr;
         nxt++;
         gap_cnt  = 0;
      end
      done = (nxt == N) && !busy && !e_rsp;
   endtask

   initial begin
      //            wr    addr          wdata          rdata          waits err gap acc exp_rd         err to
      tbl[0] = mk(1'b1, 32'h0000_0004, 32'h0000_0080, 32'hDEAD_BEEF, 0,  1'b0, 2, 1, 32'h0000_0000, 1'b0, 1'b0);
      tbl[1] = mk(1'b0, 32'h0000_0000, 32'h0000_1111, 32'h0000_03E8, 2,  1'b0, 6, 3, 32'h0000_03E8, 1'b0, 1'b0);
      tbl[2] = mk(1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_55AA, 0,  1'b1, 1, 1, 32'h0000_55AA, 1'b1, 1'b0);
      tbl[3] = mk(1'b0, 32'h0000_0014, 32'h0000_0000, 32'h0000_ABCD, 99, 1'b0, 6, 4, 32'h0000_0000, 1'b1, 1'b1);
      tbl[4] = mk(1'b0, 32'h0000_0018, 32'h0000_0000, 32'h0000_1234, 3,  1'b0, 2, 4, 32'h0000_1234, 1'b0, 1'b0);
      tbl[5] = mk(1'b1, 32'h0000_000C, 32'h0000_0001, 32'h0000_7777, 0,  1'b0, 6, 1, 32'h0000_0000, 1'b0, 1'b0);
      tbl[6] = mk(1'b0, 32'h0000_000C, 32'h0000_0000, 32'h0000_0001, 0,  1'b0, 0, 1, 32'h0000_0001, 1'b0, 1'b0);
      tbl[7] = mk(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_9999, 1,  1'b1, 0, 2, 32'h0000_0000, 1'b1, 1'b0);

      PRESET          = 1'b1;
      bus.req_valid_i = 1'b0;
      bus.req_write_i = 1'b0;
      bus.req_addr_i  = '0;
      bus.req_wdata_i = '0;
      bus.PREADY      = 1'b0;
      bus.PSLAVEERR   = 1'b0;
      bus.PRDATA      = '0;

      #3;
      chk("rst_psel",      bus.PSEL,          1'b0);
      chk("rst_penable",   bus.PENABLE,       1'b0);
      chk("rst_paddr",     bus.PADDR,         32'h0);
      chk("rst_pwdata",    bus.PWDATA,        32'h0);
      chk("rst_pwrite",    bus.PWRITE,        1'b0);
      chk("rst_rsp_valid", bus.rsp_valid_o,   1'b0);
      chk("rst_rsp_rdata", bus.rsp_rdata_o,   32'h0);
      chk("rst_rsp_err",   bus.rsp_err_o,     1'b0);
      chk("rst_rsp_to",    bus.rsp_timeout_o, 1'b0);
      chk("rst_ready",     bus.req_ready_o,   1'b1);
      #9 PRESET = 1'b0;

      for (int cyc = 0; cyc < 600 && !done; cyc++) begin
         @(negedge PCLK);
         step();
      end
      chk("sequence_done", done, 1'b1);
      chk("rsp_count",     rsp_idx, N);

      // Asynchronous reset while the slave stalls in ACCESS.
      @(negedge PCLK);
      bus.req_valid_i = 1'b1;
      bus.req_write_i = 1'b1;
      bus.req_addr_i  = 32'h0000_0008;
      bus.req_wdata_i = 32'h0000_0077;
      bus.PREADY      = 1'b0;
      bus.PSLAVEERR   = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge PCLK);
         seen = (bus.PENABLE === 1'b1);
      end
      chk("mid_reach_access", seen, 1'b1);
      bus.req_valid_i = 1'b0;
      #2 PRESET = 1'b1;
      #1;
      chk("mid_psel",      bus.PSEL,        1'b0);
      chk("mid_penable",   bus.PENABLE,     1'b0);
      chk("mid_paddr",     bus.PADDR,       32'h0);
      chk("mid_rsp_valid", bus.rsp_valid_o, 1'b0);
      chk("mid_ready",     bus.req_ready_o, 1'b1);
      repeat (2) @(negedge PCLK);
      PRESET = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         chk("post_rsp_valid", bus.rsp_valid_o, 1'b0);
         chk("post_ready",     bus.req_ready_o, 1'b1);
         chk("post_psel",      bus.PSEL,        1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
